serdesphy_pll_trim_cal: RTL

Sequencer that calibrates the analog PLL VCO coarse trim. It sweeps all 16 trim codes; for each code it pulses PLL reset, waits for settling, then checks lock and health over a measurement window. It selects the centre of the passing range and drives that code into the PLL controller's vco_trim input. It sits between the CSR block and the PLL controller, on the 24 MHz reference domain.

---
 rtl/serdesphy_pll_trim_cal.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/serdesphy_pll_trim_cal.sv
// PLL VCO coarse-trim calibration sequencer: sweeps all 16 trim codes, scores
// lock/health per code and drives the centre of the passing range to vco_trim.
module serdesphy_pll_trim_cal #(
    parameter int RST_CYCLES    = 24,
    parameter int SETTLE_CYCLES = 2400,
    parameter int MEAS_CYCLES   = 240,
    parameter int CNT_W         = 16
) (
    input  logic        clk_ref_24m,
    input  logic        rst_n,
    input  logic        phy_en,
    input  logic        cal_start,
    input  logic        cal_abort,
    input  logic        pll_lock_raw,
    input  logic        pll_vco_ok,
    input  logic        pll_cp_ok,
    output logic [3:0]  cal_trim,
    output logic        pll_rst_req,
    output logic        cal_busy,
    output logic        cal_done,
    output logic        cal_fail,
    output logic [3:0]  cal_code,
    output logic [15:0] cal_pass_map
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_EVAL    = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAIL    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_CYCLES - 1);
    localparam logic [3:0]       TRIM_DEF    = 4'h8;

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]  code_q, code_d;
    logic        good_q, good_d;
    logic [3:0]  trim_q, trim_d;
    logic        rst_req_q, rst_req_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] map_q, map_d;

    logic abort_req;
    logic start_ok;
    logic in_sweep;
    logic good_now;

    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic [3:0] highest_set(input logic [15:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Sum kept 5 bits wide so lo+hi cannot wrap before halving.
    function automatic logic [3:0] midpoint(input logic [3:0] lo, input logic [3:0] hi);
        logic [4:0] s;
        s = {1'b0, lo} + {1'b0, hi};
        return s[4:1];
    endfunction

    assign abort_req = cal_abort || !phy_en;
    assign start_ok  = cal_start && phy_en && !cal_abort;
    assign in_sweep  = (state_q == ST_RESET) || (state_q == ST_SETTLE) ||
                       (state_q == ST_MEASURE) || (state_q == ST_EVAL);
    assign good_now  = good_q & pll_lock_raw & pll_vco_ok & pll_cp_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        good_d  = good_q;
        trim_d  = trim_q;
        done_d  = done_q;
        fail_d  = fail_q;
        sel_d   = sel_q;
        map_d   = map_q;

        if (in_sweep && abort_req) begin
            // Partial pass map is deliberately kept for debug visibility.
            state_d = ST_IDLE;
            trim_d  = TRIM_DEF;
            done_d  = 1'b0;
            fail_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start_ok) begin
                        state_d = ST_RESET;
                        code_d  = 4'd0;
                        trim_d  = 4'd0;
                        map_d   = 16'd0;
                        done_d  = 1'b0;
                        fail_d  = 1'b0;
                        cnt_d   = '0;
                        good_d  = 1'b1;
                    end else if (abort_req) begin
                        state_d = ST_IDLE;
                        trim_d  = TRIM_DEF;
                        done_d  = 1'b0;
                        fail_d  = 1'b0;
                    end
                end
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_MEASURE;
                        cnt_d   = '0;
                        good_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    good_d = good_now;
                    if (cnt_q == MEAS_LAST) begin
                        map_d[code_q] = good_now;
                        cnt_d         = '0;
                        if (code_q == 4'd15) begin
                            state_d = ST_EVAL;
                        end else begin
                            code_d  = code_q + 4'd1;
                            trim_d  = code_q + 4'd1;
                            state_d = ST_RESET;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (map_q == 16'd0) begin
                        state_d = ST_FAIL;
                        sel_d   = TRIM_DEF;
                        trim_d  = TRIM_DEF;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        sel_d   = midpoint(lowest_set(map_q), highest_set(map_q));
                        trim_d  = midpoint(lowest_set(map_q), highest_set(map_q));
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    trim_d  = TRIM_DEF;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            endcase
        end

        busy_d    = (state_d == ST_RESET) || (state_d == ST_SETTLE) ||
                    (state_d == ST_MEASURE) || (state_d == ST_EVAL);
        rst_req_d = (state_d == ST_RESET);
    end

    always_ff @(posedge clk_ref_24m) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            code_q    <= 4'd0;
            good_q    <= 1'b1;
            trim_q    <= TRIM_DEF;
            rst_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            sel_q     <= TRIM_DEF;
            map_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            good_q    <= good_d;
            trim_q    <= trim_d;
            rst_req_q <= rst_req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            sel_q     <= sel_d;
            map_q     <= map_d;
        end
    end

    assign cal_trim     = trim_q;
    assign pll_rst_req  = rst_req_q;
    assign cal_busy     = busy_q;
    assign cal_done     = done_q;
    assign cal_fail     = fail_q;
    assign cal_code     = sel_q;
    assign cal_pass_map = map_q;

endmodule
